uart_tx_ctrl: RTL and testbench
===============================

Name: uart_tx_ctrl

Overview:
Serial transmit controller for the UART path, the transmit-side counterpart of the receive bit timer and packet framing. It accepts a parallel data word over a valid/ready handshake and serialises it onto a single line. Each frame is a start bit, then data_size data bits LSB first, then one stop bit. Bit timing is generated internally from a programmable bit_period, and the block sits between the host-side transmit buffer and the TX pin.

Parameters:
DATA_W, 8, maximum data bits per frame; width of tx_data
CNT_W, 14, width of bit-period counter and bit_period port

Ports:
clk  input  1  system clock; all logic on rising edge
n_rst  input  1  synchronous active-low reset
bit_period  input  CNT_W  clock cycles per serial bit; sampled at frame accept
data_size  input  4  data bits per frame; sampled at frame accept
tx_data  input  DATA_W  word to transmit; sampled at frame accept
tx_valid  input  1  host has a word ready
tx_ready  output  1  block can accept a word this cycle
tx_out  output  1  serial line; idle high
tx_busy  output  1  frame in progress (any state other than IDLE)
tx_done  output  1  one-cycle pulse when a frame completes

Behaviour:
- Reset: clk and n_rst only; synchronous, active-low. While n_rst=0 at a rising edge, the next state is tx_out=1, tx_ready=1, tx_busy=0, tx_done=0, FSM=IDLE, all counters 0.
- Reset mid-frame aborts the frame. tx_out is high on the cycle after the reset edge. There is no tx_done for the aborted frame.
- FSM states: IDLE, START, DATA, STOP. PARITY is added under the optional feature.
- IDLE: tx_out=1, tx_ready=1.
- Accept: tx_valid=1 and tx_ready=1 at an edge.
  - The block latches tx_data into the shift register, and latches bit_period and data_size.
  - It moves to START; tx_out=0 from the next cycle.
  - tx_ready is combinationally equal to (state==IDLE).
- Bit timer:
  - The counter counts 1..bit_period. The bit ends at the cycle where the count equals the latched period; the counter then reloads to 1.
  - Each bit is held for exactly period cycles.
  - A latched bit_period of 0 is treated as 1.
- START: drive 0 for one bit, then go to DATA with bit index 0.
- DATA:
  - Drive shift_reg[0]; shift right at each bit end.
  - After the bit with index n-1, go to STOP. n is the latched data_size.
  - data_size of 0 is treated as 1; values above DATA_W are treated as DATA_W.
- STOP: drive 1 for one bit. At the bit end, go to IDLE and assert tx_done=1 for exactly the first IDLE cycle.
- Frame timing: with accept at edge E, tx_out=0 starts at E+1 and the frame occupies (n+2)*period cycles.
- Back-to-back: tx_valid held high gives a minimum of one IDLE cycle (tx_out=1) between the stop bit and the next start bit. In that IDLE cycle, tx_done=1 and tx_ready=1 coincide.
- Config changes: changes to bit_period, data_size or tx_data during a frame have no effect until the next accept.
- tx_valid=0 in IDLE: the block stays in IDLE indefinitely with tx_out=1.

Optional Feature:
UART_TX_PARITY_EN
- Defined:
  - A PARITY state is inserted between DATA and STOP. It drives the even-parity bit, i.e. the XOR of the n transmitted data bits, latched at accept, for one bit period.
  - Frame length becomes (n+3)*period.
- Undefined: the PARITY state and its logic are absent, and the frame is exactly as above.

Test Plan:
1. Reset then idle: n_rst=0 for 2 cycles, then 1, tx_valid=0 for 50 cycles -> tx_out=1, tx_ready=1, tx_busy=0, tx_done=0 throughout.
2. Basic frame: bit_period=10, data_size=8, tx_data=0xA5, one-cycle tx_valid.
   - tx_out bit sequence 0,1,0,1,0,0,1,0,1,1, each bit exactly 10 cycles.
   - tx_done pulses once, 101 cycles after the accept edge.
   - tx_ready=0 for cycles 1..100.
3. Short word and minimum period: bit_period=1, data_size=5, tx_data=0xFF -> tx_out sequence 0,1,1,1,1,1,1 at one bit per cycle; bits 5-7 are not sent.
4. Back-to-back and config isolation: tx_valid held high with 0x00 then 0xFF, and bit_period changed 4->8 mid-frame.
   - The first frame uses period 4 throughout.
   - Exactly one idle-high cycle (tx_done=1) separates the frames.
   - The second frame uses period 8.
5. Reset mid-frame: n_rst=0 during the DATA bit with index 3 -> tx_out=1 next cycle, no tx_done, and a subsequent frame with 0x3C transmits correctly.
6. With UART_TX_PARITY_EN: data_size=8, tx_data=0x07 -> parity bit 1 between data and stop, and tx_done after 11*period+1 cycles.

Source files
------------

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl -- UART serial transmit controller.
//
// Accepts a parallel word over a valid/ready handshake and sends it on tx_out
// as a frame: a start bit (0), then data_size data bits LSB first, then one
// stop bit (1). Bit timing comes from bit_period, a count of clock cycles per
// bit. bit_period, data_size and tx_data are all captured when a word is
// accepted.
//
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit
// between the last data bit and the stop bit.
//
// Ports:
//   clk        in   system clock, rising edge
//   n_rst      in   synchronous active-low reset
//   bit_period in   [CNT_W]  cycles per bit (0 is treated as 1)
//   data_size  in   [4]      data bits per frame (clamped to 1..DATA_W)
//   tx_data    in   [DATA_W] word to transmit
//   tx_valid   in   host has a word ready
//   tx_ready   out  block accepts a word this cycle (state is IDLE)
//   tx_out     out  serial line, idle high
//   tx_busy    out  frame in progress
//   tx_done    out  one-cycle pulse on the first IDLE cycle after a frame
module uart_tx_ctrl #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 14
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic [CNT_W-1:0]  bit_period,
  input  logic [3:0]        data_size,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_out,
  output logic              tx_busy,
  output logic              tx_done
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   shift_q;
  logic [CNT_W-1:0]    period_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [3:0]          nbits_q;
  logic [3:0]          bit_idx_q;
  logic                done_q;

  logic                accept;
  logic                bit_end;
  logic                last_bit;
  logic [CNT_W-1:0]    period_eff;
  logic [3:0]          size_eff;

`ifdef UART_TX_PARITY_EN
  logic                parity_q;
  logic                parity_eff;
`endif

  // Effective configuration captured at accept time.
  always_comb begin
    period_eff = (bit_period == '0) ? CNT_W'(1) : bit_period;
    if (data_size == '0)
      size_eff = 4'd1;
    else if (32'(data_size) > DATA_W)
      size_eff = 4'(DATA_W);
    else
      size_eff = data_size;
  end

`ifdef UART_TX_PARITY_EN
  // Even parity over only the bits that will actually be sent.
  always_comb begin
    parity_eff = 1'b0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      if (i < 32'(size_eff))
        parity_eff = parity_eff ^ tx_data[i];
    end
  end
`endif

  assign accept   = tx_valid && (state_q == IDLE);
  assign bit_end  = (cnt_q == period_q);
  assign last_bit = (bit_idx_q == nbits_q - 4'd1);

  // Next-state and line output.
  always_comb begin
    state_d = state_q;
    tx_out  = 1'b1;
    unique case (state_q)
      IDLE: begin
        if (tx_valid) state_d = START;
      end
      START: begin
        tx_out = 1'b0;
        if (bit_end) state_d = DATA;
      end
      DATA: begin
        tx_out = shift_q[0];
        if (bit_end && last_bit) begin
`ifdef UART_TX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        tx_out = parity_q;
        if (bit_end) state_d = STOP;
      end
`endif
      STOP: begin
        if (bit_end) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      period_q  <= '0;
      cnt_q     <= '0;
      nbits_q   <= '0;
      bit_idx_q <= '0;
      done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == STOP) && bit_end;
      if (accept) begin
        shift_q   <= tx_data;
        period_q  <= period_eff;
        nbits_q   <= size_eff;
        cnt_q     <= CNT_W'(1);
        bit_idx_q <= '0;
`ifdef UART_TX_PARITY_EN
        parity_q  <= parity_eff;
`endif
      end else if (state_q != IDLE) begin
        // Counter runs 1..period and reloads to 1 at each bit end.
        if (bit_end)
          cnt_q <= CNT_W'(1);
        else
          cnt_q <= cnt_q + CNT_W'(1);
        if (bit_end && (state_q == DATA)) begin
          shift_q   <= shift_q >> 1;
          bit_idx_q <= bit_idx_q + 4'd1;
        end
      end
    end
  end

  assign tx_ready = (state_q == IDLE);
  assign tx_busy  = (state_q != IDLE);
  assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl -- directed self-checking bench for uart_tx_ctrl.
// Build with UART_TX_PARITY_EN defined to exercise the parity bit.
module tb_uart_tx_ctrl;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 14;

  logic              clk = 1'b0;
  logic              n_rst;
  logic [CNT_W-1:0]  bit_period;
  logic [3:0]        data_size;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              tx_out;
  logic              tx_busy;
  logic              tx_done;

  uart_tx_ctrl #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .bit_period (bit_period),
    .data_size  (data_size),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_out     (tx_out),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // Captured waveform; index 0 is the cycle right after the accept edge.
  logic cap_out   [512];
  logic cap_ready [512];
  logic cap_busy  [512];
  int   done_at;

  // Expected frame bits (start, data, [parity], stop).
  logic exp_bits [16];
  int   exp_len;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic build_exp(input logic [7:0] d, input int sz);
    int   n;
    logic p;
    n = (sz == 0) ? 1 : ((sz > 8) ? 8 : sz);
    p = 1'b0;
    exp_bits[0] = 1'b0;
    for (int i = 0; i < n; i++) begin
      exp_bits[1 + i] = d[i];
      p = p ^ d[i];
    end
`ifdef UART_TX_PARITY_EN
    exp_bits[n + 1] = p;
    exp_bits[n + 2] = 1'b1;
    exp_len = n + 3;
`else
    exp_bits[n + 1] = 1'b1;
    exp_len = n + 2;
`endif
  endtask

  // Records outputs each cycle until tx_done is seen or the budget expires.
  task automatic capture(input int max_cycles);
    done_at = -1;
    for (int j = 0; j < max_cycles; j++) begin
      cap_out[j]   = tx_out;
      cap_ready[j] = tx_ready;
      cap_busy[j]  = tx_busy;
      if (tx_done === 1'b1) begin
        done_at = j;
        break;
      end
      tick;
    end
  endtask

  // Counts cycles in the captured frame that deviate from exp_bits at the
  // given period (line level, tx_ready low, tx_busy high).
  task automatic scan_frame(input int period, output int bad, output int first_bad);
    int lim;
    bad = 0;
    first_bad = -1;
    lim = exp_len * period;
    if (done_at >= 0 && done_at < lim) lim = done_at;
    for (int j = 0; j < lim; j++) begin
      if (cap_out[j] !== exp_bits[j / period] || cap_ready[j] !== 1'b0 ||
          cap_busy[j] !== 1'b1) begin
        if (first_bad < 0) first_bad = j;
        bad++;
      end
    end
  endtask

  task automatic start_frame(input int period, input int sz, input logic [7:0] d, input bit hold);
    bit_period = CNT_W'(period);
    data_size  = 4'(sz);
    tx_data    = d;
    tx_valid   = 1'b1;
    tick;
    if (!hold) tx_valid = 1'b0;
  endtask

  task automatic test_reset;
    logic [3:0] obs;
    n_rst = 1'b0;
    tx_valid = 1'b0;
    tick;
    tick;
    n_rst = 1'b1;
    for (int c = 0; c < 50; c++) begin
      obs = {tx_out, tx_ready, tx_busy, tx_done};
      tests_run++;
      if (obs !== 4'b1100) begin
        tests_failed++;
        $display("FAIL reset_idle cycle %0d: out/ready/busy/done=%b required 1100", c, obs);
      end
      tick;
    end
  endtask

  task automatic test_basic_frame;
    int bad, fb;
    build_exp(8'hA5, 8);
    start_frame(10, 8, 8'hA5, 1'b0);
    capture(exp_len * 10 + 5);
    scan_frame(10, bad, fb);
    tests_run++;
    if (bad !== 0) begin
      tests_failed++;
      $display("FAIL basic_frame: %0d bad cycles (first %0d), required 0", bad, fb);
    end
    tests_run++;
    if (done_at !== exp_len * 10) begin
      tests_failed++;
      $display("FAIL basic_done_time: done at %0d, required %0d", done_at, exp_len * 10);
    end
    tests_run++;
    if ({tx_out, tx_ready} !== 2'b11) begin
      tests_failed++;
      $display("FAIL basic_done_idle: out/ready=%b required 11", {tx_out, tx_ready});
    end
    tick;
    tests_run++;
    if (tx_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_done_pulse: tx_done=%b one cycle later, required 0", tx_done);
    end
  endtask

  task automatic test_short_word;
    int bad, fb;
    build_exp(8'hFF, 5);
    start_frame(1, 5, 8'hFF, 1'b0);
    capture(exp_len + 5);
    scan_frame(1, bad, fb);
    tests_run++;
    if (bad !== 0) begin
      tests_failed++;
      $display("FAIL short_word: %0d bad cycles (first %0d), required 0", bad, fb);
    end
    tests_run++;
    if (done_at !== exp_len) begin
      tests_failed++;
      $display("FAIL short_done_time: done at %0d, required %0d", done_at, exp_len);
    end
    tick;
  endtask

  // Zero period and zero size clamp to 1; oversize clamps to DATA_W.
  task automatic test_clamp;
    int bad, fb;
    build_exp(8'h01, 0);
    start_frame(0, 0, 8'h01, 1'b0);
    capture(exp_len + 5);
    scan_frame(1, bad, fb);
    tests_run++;
    if (bad !== 0 || done_at !== exp_len) begin
      tests_failed++;
      $display("FAIL clamp_zero: %0d bad cycles, done at %0d, required 0 and %0d", bad, done_at, exp_len);
    end
    tick;
    build_exp(8'h81, 15);
    start_frame(2, 15, 8'h81, 1'b0);
    capture(exp_len * 2 + 5);
    scan_frame(2, bad, fb);
    tests_run++;
    if (bad !== 0 || done_at !== exp_len * 2) begin
      tests_failed++;
      $display("FAIL clamp_over: %0d bad cycles, done at %0d, required 0 and %0d", bad, done_at, exp_len * 2);
    end
    tick;
  endtask

  task automatic test_back_to_back;
    int bad, fb;
    build_exp(8'h00, 8);
    start_frame(4, 8, 8'h00, 1'b1);
    tx_data    = 8'hFF;
    bit_period = CNT_W'(8);
    capture(exp_len * 4 + 5);
    scan_frame(4, bad, fb);
    tests_run++;
    if (bad !== 0 || done_at !== exp_len * 4) begin
      tests_failed++;
      $display("FAIL b2b_first: %0d bad cycles (first %0d), done at %0d, required 0 and %0d", bad, fb, done_at, exp_len * 4);
    end
    tests_run++;
    if ({tx_out, tx_ready, tx_done} !== 3'b111) begin
      tests_failed++;
      $display("FAIL b2b_gap: out/ready/done=%b required 111", {tx_out, tx_ready, tx_done});
    end
    tick;
    tx_valid = 1'b0;
    build_exp(8'hFF, 8);
    capture(exp_len * 8 + 5);
    scan_frame(8, bad, fb);
    tests_run++;
    if (bad !== 0 || done_at !== exp_len * 8) begin
      tests_failed++;
      $display("FAIL b2b_second: %0d bad cycles (first %0d), done at %0d, required 0 and %0d", bad, fb, done_at, exp_len * 8);
    end
    tick;
  endtask

  task automatic test_reset_mid_frame;
    int bad, fb, dones;
    start_frame(4, 8, 8'h55, 1'b0);
    // Observation 17 lies inside data bit index 3 (cycles 16..19).
    for (int c = 0; c < 17; c++) tick;
    n_rst = 1'b0;
    tick;
    n_rst = 1'b1;
    tests_run++;
    if ({tx_out, tx_ready, tx_busy, tx_done} !== 4'b1100) begin
      tests_failed++;
      $display("FAIL reset_abort: out/ready/busy/done=%b required 1100", {tx_out, tx_ready, tx_busy, tx_done});
    end
    dones = 0;
    for (int c = 0; c < 60; c++) begin
      if (tx_done === 1'b1) dones++;
      tick;
    end
    tests_run++;
    if (dones !== 0) begin
      tests_failed++;
      $display("FAIL reset_no_done: %0d tx_done pulses, required 0", dones);
    end
    build_exp(8'h3C, 8);
    start_frame(4, 8, 8'h3C, 1'b0);
    capture(exp_len * 4 + 5);
    scan_frame(4, bad, fb);
    tests_run++;
    if (bad !== 0 || done_at !== exp_len * 4) begin
      tests_failed++;
      $display("FAIL reset_recover: %0d bad cycles (first %0d), done at %0d, required 0 and %0d", bad, fb, done_at, exp_len * 4);
    end
    tick;
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity;
    int bad, fb;
    build_exp(8'h07, 8);
    start_frame(3, 8, 8'h07, 1'b0);
    capture(11 * 3 + 5);
    scan_frame(3, bad, fb);
    tests_run++;
    if (cap_out[9 * 3] !== 1'b1) begin
      tests_failed++;
      $display("FAIL parity_bit: line=%b during parity bit, required 1", cap_out[9 * 3]);
    end
    tests_run++;
    if (bad !== 0 || done_at !== 11 * 3) begin
      tests_failed++;
      $display("FAIL parity_frame: %0d bad cycles (first %0d), done at %0d, required 0 and %0d", bad, fb, done_at, 11 * 3);
    end
    tick;
  endtask
`endif

  initial begin
    n_rst      = 1'b0;
    tx_valid   = 1'b0;
    bit_period = '0;
    data_size  = '0;
    tx_data    = '0;
    test_reset;
    test_basic_frame;
    test_short_word;
    test_clamp;
    test_back_to_back;
    test_reset_mid_frame;
`ifdef UART_TX_PARITY_EN
    test_parity;
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
